// File: rtl/ysyx_22050019_mem_arb.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// One transaction in flight; a WAIT watchdog turns a missing response into an error response.
module ysyx_22050019_mem_arb #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic                if_rsp_err,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_rsp_valid,
  output logic                ls_rsp_err,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  // state | meaning
  // IDLE  | no transaction; grant decided combinationally from valids and last_grant
  // REQ   | captured request presented to memory until accepted
  // WAIT  | waiting for memory response, watchdog counting
  // RESP  | one-cycle response pulse to the owner
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam int MASK_W    = DATA_W / 8;
  localparam int CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TC_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TC_LAST_I);
  localparam bit   TO_EN   = (TIMEOUT_CYC != 0);

  state_t              state_q, state_d;
  logic                last_ls_q;
  logic                own_ls_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                grant_if, grant_ls;
  logic                rsp_hit, tmo_hit, done;
  logic [DATA_W-1:0]   rsp_data;

  // On a tie the requester that did not win last time gets the port.
  assign grant_if = (state_q == IDLE) & if_req_valid & (~ls_req_valid | last_ls_q);
  assign grant_ls = (state_q == IDLE) & ls_req_valid & (~if_req_valid | ~last_ls_q);

  // A response landing on the final watchdog cycle still counts as a good response.
  assign rsp_hit  = (state_q == WAIT) & mem_rsp_valid;
  assign tmo_hit  = TO_EN & (state_q == WAIT) & ~mem_rsp_valid & (cnt_q == TC_LAST);
  assign done     = rsp_hit | tmo_hit;
  assign rsp_data = (rsp_hit & ~we_q) ? mem_rdata : '0;

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if_req_ready = grant_if;
        ls_req_ready = grant_ls;
        if (grant_if | grant_ls) state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (done) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_ls_q    <= 1'b1;
      own_ls_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      cnt_q        <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      if_rdata     <= '0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_err   <= 1'b0;
      ls_rdata     <= '0;
    end else begin
      state_q <= state_d;

      // Requesters may move on after the handshake; memory only ever sees this copy.
      if (grant_if | grant_ls) begin
        own_ls_q  <= grant_ls;
        last_ls_q <= grant_ls;
        we_q      <= grant_ls & ls_we;
        addr_q    <= grant_ls ? ls_addr : if_addr;
        wdata_q   <= grant_ls ? ls_wdata : '0;
        wmask_q   <= grant_ls ? ls_wmask : '0;
      end

      if (state_q == REQ) begin
        cnt_q <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if_rsp_valid <= done & ~own_ls_q;
      ls_rsp_valid <= done & own_ls_q;
      if (done & ~own_ls_q) begin
        if_rdata   <= rsp_data;
        if_rsp_err <= tmo_hit;
      end
      if (done & own_ls_q) begin
        ls_rdata   <= rsp_data;
        ls_rsp_err <= tmo_hit;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_mem_arb.sv
// Bench for the IF/LS memory arbiter: table of directed transactions, then randomized
// transactions checked against a transaction-level round-robin/timeout model.
module tb_ysyx_22050019_mem_arb;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_addr;
  logic        if_rsp_valid, if_rsp_err;
  logic [63:0] if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_we;
  logic [63:0] ls_addr, ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_rsp_valid, ls_rsp_err;
  logic [63:0] ls_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  ysyx_22050019_mem_arb #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_err(if_rsp_err), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_err(ls_rsp_err), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  // One transaction: request pattern, memory behaviour and the expected outcome.
  // rdy    : cycles mem_req_ready is held low before acceptance
  // rsp_at : WAIT cycle (1-based) on which memory answers
  // rst_w  : WAIT cycle on which rst_n is pulsed low (0 = never)
  typedef struct {
    logic        ifv, lsv, we;
    logic [63:0] if_addr, ls_addr, wdata, mdata;
    logic [7:0]  wmask;
    int          rdy, rsp_at, rst_w;
    logic        exp_ls, exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  int          errs = 0;
  int          checks = 0;
  logic        last_ls;
  logic        have_prev;
  logic        prev_ls;
  logic [63:0] held_rdata;
  logic        held_err;
  vec_t        tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic vec_t mk(input logic ifv, lsv, we, input logic [63:0] ia, la, wd,
                              input logic [7:0] wm, input int rdy, rsp_at,
                              input logic [63:0] md, input int rst_w,
                              input logic e_ls, e_err, input logic [63:0] e_rd);
    vec_t v;
    v.ifv = ifv; v.lsv = lsv; v.we = we; v.if_addr = ia; v.ls_addr = la; v.wdata = wd;
    v.wmask = wm; v.rdy = rdy; v.rsp_at = rsp_at; v.mdata = md; v.rst_w = rst_w;
    v.exp_ls = e_ls; v.exp_err = e_err; v.exp_rdata = e_rd;
    return v;
  endfunction

  // Reference model: round-robin on ties, timeout after TO silent WAIT cycles,
  // stores and timeouts return zero data.
  function automatic vec_t rnd_vec(input bit both);
    vec_t v;
    int   pick;
    pick = both ? 3 : $urandom_range(1, 3);
    v.ifv = pick[0]; v.lsv = pick[1];
    v.we = 1'($urandom_range(0, 1));
    v.if_addr = rnd64(); v.ls_addr = rnd64(); v.wdata = rnd64(); v.mdata = rnd64();
    v.wmask = 8'($urandom);
    v.rdy = $urandom_range(0, 3);
    v.rsp_at = $urandom_range(1, 6);
    v.rst_w = 0;
    v.exp_ls = (v.ifv && v.lsv) ? !last_ls : v.lsv;
    v.exp_err = (v.rsp_at > TO);
    v.exp_rdata = (v.exp_err || (v.exp_ls && v.we)) ? 64'd0 : v.mdata;
    return v;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_if_rsp_valid", if_rsp_valid, 0);
    chk("rst_ls_rsp_valid", ls_rsp_valid, 0);
    chk("rst_if_err", if_rsp_err, 0);
    chk("rst_ls_err", ls_rsp_err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
  task automatic run_txn(input vec_t v);
    int          nw;
    logic [63:0] eaddr;
    nw = (v.rsp_at <= TO) ? v.rsp_at : TO;
    eaddr = v.exp_ls ? v.ls_addr : v.if_addr;

    if_req_valid = v.ifv; ls_req_valid = v.lsv; ls_we = v.we;
    if_addr = v.if_addr; ls_addr = v.ls_addr; ls_wdata = v.wdata; ls_wmask = v.wmask;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rdata = rnd64();
    #1;
    chk("if_req_ready", if_req_ready, !v.exp_ls);
    chk("ls_req_ready", ls_req_ready, v.exp_ls);
    chk("busy_idle", busy, 0);
    chk("if_rsp_pulse_len", if_rsp_valid, 0);
    chk("ls_rsp_pulse_len", ls_rsp_valid, 0);
    if (have_prev) begin
      chk("rdata_held", prev_ls ? ls_rdata : if_rdata, held_rdata);
      chk("err_held", prev_ls ? ls_rsp_err : if_rsp_err, held_err);
    end
    @(posedge clk); @(negedge clk);

    if_addr = rnd64(); ls_addr = rnd64(); ls_wdata = rnd64();
    ls_wmask = 8'($urandom); ls_we = 1'($urandom_range(0, 1));
    for (int r = 0; r <= v.rdy; r++) begin
      mem_req_ready = (r == v.rdy);
      mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rdata = rnd64();
      #1;
      chk("mem_req_valid", mem_req_valid, 1);
      chk("mem_we", mem_we, v.exp_ls & v.we);
      chk("mem_addr", mem_addr, eaddr);
      chk("mem_wmask", mem_wmask, v.exp_ls ? v.wmask : 8'h00);
      if (v.exp_ls) chk("mem_wdata", mem_wdata, v.wdata);
      chk("if_ready_busy", if_req_ready, 0);
      chk("ls_ready_busy", ls_req_ready, 0);
      chk("busy_req", busy, 1);
      @(posedge clk); @(negedge clk);
    end
    mem_req_ready = 1'b0;

    for (int w = 1; w <= nw; w++) begin
      mem_rsp_valid = (w == v.rsp_at);
      mem_rdata = (w == v.rsp_at) ? v.mdata : rnd64();
      if (w == v.rst_w) rst_n = 1'b0;
      #1;
      chk("mem_req_valid_wait", mem_req_valid, 0);
      chk("if_rsp_wait", if_rsp_valid, 0);
      chk("ls_rsp_wait", ls_rsp_valid, 0);
      chk("busy_wait", busy, 1);
      @(posedge clk); @(negedge clk);
      if (w == v.rst_w) begin
        rst_n = 1'b1; mem_rsp_valid = 1'b0;
        #1;
        chk_reset_outputs();
        last_ls = 1'b1; have_prev = 1'b0;
        return;
      end
    end

    mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rdata = rnd64();
    #1;
    chk("if_rsp_valid", if_rsp_valid, !v.exp_ls);
    chk("ls_rsp_valid", ls_rsp_valid, v.exp_ls);
    chk("rsp_rdata", v.exp_ls ? ls_rdata : if_rdata, v.exp_rdata);
    chk("rsp_err", v.exp_ls ? ls_rsp_err : if_rsp_err, v.exp_err);
    chk("if_ready_resp", if_req_ready, 0);
    chk("ls_ready_resp", ls_req_ready, 0);
    chk("busy_resp", busy, 1);
    last_ls = v.exp_ls;
    have_prev = 1'b1; prev_ls = v.exp_ls;
    held_rdata = v.exp_rdata; held_err = v.exp_err;
    @(posedge clk); @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    if_req_valid = 0; ls_req_valid = 0; ls_we = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_wmask = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    last_ls = 1'b1; have_prev = 1'b0; prev_ls = 1'b0; held_rdata = 0; held_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_outputs();
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    //             ifv lsv we  if_addr        ls_addr        wdata          wmask rdy rsp mdata  rst ls err rdata
    tbl[0] = mk(1, 0, 0, 64'h8000_0000, 64'h0,         64'h0,         8'h00, 0, 1,  64'h13,   0, 0, 0, 64'h13);
    tbl[1] = mk(0, 1, 1, 64'h0,         64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 0, 1,  64'h5555, 0, 1, 0, 64'h0);
    tbl[2] = mk(1, 1, 0, 64'h8000_0004, 64'h8000_2000, 64'h0,         8'hFF, 0, 1,  64'h1111, 0, 0, 0, 64'h1111);
    tbl[3] = mk(1, 1, 0, 64'h8000_0008, 64'h8000_2008, 64'h0,         8'hFF, 0, 2,  64'h2222, 0, 1, 0, 64'h2222);
    tbl[4] = mk(1, 1, 1, 64'h8000_000C, 64'h8000_2010, 64'h77,        8'h01, 5, 1,  64'h3333, 0, 0, 0, 64'h3333);
    tbl[5] = mk(1, 1, 1, 64'h8000_0010, 64'h8000_2018, 64'hCAFE,      8'h03, 1, 10, 64'h9999, 0, 1, 1, 64'h0);
    tbl[6] = mk(1, 1, 0, 64'h8000_0014, 64'h8000_2020, 64'h0,         8'h00, 0, 4,  64'h4444, 0, 0, 0, 64'h4444);
    tbl[7] = mk(1, 1, 0, 64'h8000_0018, 64'h8000_2028, 64'h0,         8'h00, 0, 5,  64'h8888, 0, 1, 1, 64'h0);
    tbl[8] = mk(1, 1, 0, 64'h8000_001C, 64'h8000_2030, 64'h0,         8'h00, 0, 5,  64'h6666, 2, 0, 0, 64'h0);
    tbl[9] = mk(1, 1, 1, 64'h8000_0020, 64'h8000_2038, 64'h1234,      8'hF0, 0, 3,  64'h5A5A, 0, 0, 0, 64'h5A5A);
    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    for (int i = 0; i < 20; i++) run_txn(rnd_vec(1'b1));
    for (int i = 0; i < 40; i++) run_txn(rnd_vec(1'b0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
